// File: rtl/llist_queue.sv
// llist_queue: linked-list FIFO whose storage ids are handed out and taken back
// by an external free-list allocator (flist).
//
// A push latches the payload, asks flist for a free id, writes the payload at
// that id and chains the id behind the current tail. A pop refill reads the
// entry at head into a one-entry staging register, follows the next pointer to
// the new head and hands the old id back to flist.
//
// Ports
//   clk, rst_n              single clock, asynchronous active-low reset
//   push_valid/data/ready   push side; push_ready is a one-cycle accept strobe
//   pop_valid/data/ready    pop side; staging register held until taken
//   count, full, empty      linked entries (staging register not included)
//   init_done               flist finished its own initialisation
//   alloc_req/ack/id        id request to flist (pulses)
//   dealloc_req/id/ack      id return to flist (pulses; id held until ack)
//   dbg_state               current FSM state, for observation only
//
// Handshakes: a push transfers on a cycle where push_valid & push_ready are
// both 1; a pop transfers on a cycle where pop_valid & pop_ready are both 1.
// Once pop_valid is 1, pop_data stays stable until that transfer. The flist
// request lines are single-cycle pulses, and only one request (alloc or
// dealloc) is ever outstanding, so the two are never asserted together.
module llist_queue #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_valid,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    output logic          pop_valid,
    output logic [DW-1:0] pop_data,
    input  logic          pop_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    input  logic          init_done,
    output logic          alloc_req,
    input  logic          alloc_ack,
    input  logic [AW-1:0] alloc_id,
    output logic          dealloc_req,
    output logic [AW-1:0] dealloc_id,
    input  logic          dealloc_ack,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ALLOC   = 3'd1,
        S_LINK    = 3'd2,
        S_RD      = 3'd3,
        S_DEALLOC = 3'd4
    } state_t;

    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH - 1);

    state_t        state_q;
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [AW:0]   count_q;
    logic [DW-1:0] push_data_q;
    logic          alloc_req_q;
    logic          dealloc_req_q;
    logic [AW-1:0] dealloc_id_q;
    logic          pop_valid_q;
    logic [DW-1:0] pop_data_q;
    logic          rd_wait_q;

    // Payload and next-pointer stores, indexed by id, registered read port.
    logic [DW-1:0] data_mem [DEPTH];
    logic [AW-1:0] next_mem [DEPTH];
    logic [DW-1:0] rd_data_q;
    logic [AW-1:0] rd_next_q;

    logic full_w;
    logic refill_w;
    logic push_accept_w;
    logic mem_we_w;
    logic link_we_w;

    assign full_w = (count_q == CNT_FULL);

    // Refilling the pop staging register wins over a new push.
    assign refill_w      = (state_q == S_IDLE) && !pop_valid_q && (count_q != '0);
    assign push_accept_w = (state_q == S_IDLE) && !refill_w && push_valid &&
                           !full_w && init_done;

    assign mem_we_w  = (state_q == S_ALLOC) && alloc_ack;
    // The first entry of an empty list becomes head; otherwise chain behind tail.
    assign link_we_w = mem_we_w && (count_q != '0);

    always_ff @(posedge clk) begin
        if (mem_we_w) begin
            data_mem[alloc_id] <= push_data_q;
        end
        if (link_we_w) begin
            next_mem[tail_q] <= alloc_id;
        end
        // Always reading at head; the RD state waits one cycle for this data.
        rd_data_q <= data_mem[head_q];
        rd_next_q <= next_mem[head_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            push_data_q   <= '0;
            alloc_req_q   <= 1'b0;
            dealloc_req_q <= 1'b0;
            dealloc_id_q  <= '0;
            pop_valid_q   <= 1'b0;
            pop_data_q    <= '0;
            rd_wait_q     <= 1'b0;
        end else begin
            alloc_req_q   <= 1'b0;
            dealloc_req_q <= 1'b0;

            // Consumption of the staging register does not depend on the FSM.
            if (pop_valid_q && pop_ready) begin
                pop_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (refill_w) begin
                        rd_wait_q <= 1'b0;
                        state_q   <= S_RD;
                    end else if (push_accept_w) begin
                        push_data_q <= push_data;
                        alloc_req_q <= 1'b1;
                        state_q     <= S_ALLOC;
                    end
                end
                S_ALLOC: begin
                    if (alloc_ack) begin
                        if (count_q == '0) begin
                            head_q <= alloc_id;
                        end
                        tail_q  <= alloc_id;
                        count_q <= count_q + CNT_ONE;
                        state_q <= S_LINK;
                    end
                end
                S_LINK: begin
                    state_q <= S_IDLE;
                end
                S_RD: begin
                    if (!rd_wait_q) begin
                        rd_wait_q <= 1'b1;
                    end else begin
                        pop_data_q    <= rd_data_q;
                        pop_valid_q   <= 1'b1;
                        dealloc_id_q  <= head_q;
                        head_q        <= rd_next_q;
                        count_q       <= count_q - CNT_ONE;
                        dealloc_req_q <= 1'b1;
                        state_q       <= S_DEALLOC;
                    end
                end
                S_DEALLOC: begin
                    if (dealloc_ack) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign push_ready  = push_accept_w;
    assign pop_valid   = pop_valid_q;
    assign pop_data    = pop_data_q;
    assign count       = count_q;
    assign full        = full_w;
    assign empty       = (count_q == '0);
    assign alloc_req   = alloc_req_q;
    assign dealloc_req = dealloc_req_q;
    assign dealloc_id  = dealloc_id_q;
    assign dbg_state   = state_q;

endmodule
